// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_e;

    // Only NONSEQ and SEQ carry a real transfer; IDLE/BUSY always get OKAY.
    function automatic logic htrans_active(input logic [1:0] t);
        case (t)
            HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped addresses: two-cycle ERROR response plus error log.
module ahb_default_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 hclk_i,
    input  logic                 hresetn_i,
    input  logic                 sample_i,
    input  logic                 unmapped_i,
    input  logic                 active_i,
    input  logic [ADDR_W-1:0]    haddr_i,
    output logic                 hready_o,
    output logic                 hresp_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o,
    output logic [ADDR_W-1:0]    err_addr_o
);

    ds_state_e            state_q, state_d;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [ADDR_W-1:0]    err_addr_q;
    logic                 err_hit;

    // An unmapped NONSEQ/SEQ accepted on this edge starts an ERROR response.
    assign err_hit = sample_i & unmapped_i & active_i;

    // State register.
    always_ff @(posedge hclk_i or negedge hresetn_i) begin
        if (!hresetn_i) state_q <= DS_IDLE;
        else            state_q <= state_d;
    end

    // Next state and response: ERR1 is the wait cycle, ERR2 completes the ERROR.
    always_comb begin
        state_d  = state_q;
        hready_o = 1'b1;
        hresp_o  = HRESP_OKAY;
        case (state_q)
            DS_IDLE: begin
                if (err_hit) state_d = DS_ERR1;
            end
            DS_ERR1: begin
                hready_o = 1'b0;
                hresp_o  = HRESP_ERROR;
                state_d  = DS_ERR2;
            end
            DS_ERR2: begin
                hresp_o = HRESP_ERROR;
                if (sample_i) state_d = err_hit ? DS_ERR1 : DS_IDLE;
            end
            default: state_d = DS_IDLE;
        endcase
    end

    // Error log: last offending address and a saturating count.
    always_ff @(posedge hclk_i or negedge hresetn_i) begin
        if (!hresetn_i) begin
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else if (err_hit) begin
            err_addr_q <= haddr_i;
            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_cnt_o  = err_cnt_q;
    assign err_addr_o = err_addr_q;

endmodule

// File: rtl/ahb_addr_decoder_mux.sv
// AHB-Lite region decoder and slave response mux with built-in default slave.
module ahb_addr_decoder_mux
    import ahb_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RW         = 2,
    parameter int REGION_LSB = 30,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                         hclk,
    input  logic                         hresetn,
    input  logic [ADDR_W-1:0]            haddr,
    input  logic [1:0]                   htrans,
    output logic [NUM_SLAVES-1:0]        hsel,
    input  logic [NUM_SLAVES*DATA_W-1:0] hrdata_s,
    input  logic [NUM_SLAVES-1:0]        hreadyout_s,
    input  logic [NUM_SLAVES-1:0]        hresp_s,
    output logic [DATA_W-1:0]            hrdata,
    output logic                         hready,
    output logic                         hresp,
    output logic [ERR_CNT_W-1:0]         err_cnt,
    output logic [ADDR_W-1:0]            err_addr
);

    if (NUM_SLAVES > (1 << RW)) begin : g_bad_num_slaves
        $error("NUM_SLAVES exceeds the number of regions 2**RW");
    end
    if (REGION_LSB + RW > ADDR_W) begin : g_bad_region
        $error("region field REGION_LSB+RW exceeds ADDR_W");
    end

    logic [RW-1:0] idx;
    logic          unmapped;
    logic          active;
    logic [RW-1:0] dp_idx_q;
    logic          dp_unmapped_q;
    logic          dp_active_q;
    logic          ds_hready, ds_hresp;
    logic [DATA_W-1:0] sel_rdata;
    logic          sel_ready, sel_resp;

    assign idx      = haddr[REGION_LSB +: RW];
    assign unmapped = (int'(idx) >= NUM_SLAVES);
    assign active   = htrans_active(htrans);

    // One-hot address-phase select; independent of htrans.
    always_comb begin
        hsel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            hsel[i] = !unmapped && (int'(idx) == i);
        end
    end

    // Data-phase registers advance only when the bus accepts the address phase.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dp_idx_q      <= '0;
            dp_unmapped_q <= 1'b0;
            dp_active_q   <= 1'b0;
        end else if (hready) begin
            dp_idx_q      <= idx;
            dp_unmapped_q <= unmapped;
            dp_active_q   <= active;
        end
    end

    // Pick the data-phase slave's read data and handshake.
    always_comb begin
        sel_rdata = '0;
        sel_ready = 1'b1;
        sel_resp  = HRESP_OKAY;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (int'(dp_idx_q) == i) begin
                sel_rdata = hrdata_s[i*DATA_W +: DATA_W];
                sel_ready = hreadyout_s[i];
                sel_resp  = hresp_s[i];
            end
        end
    end

    // Final response: default slave, active mapped slave, or idle OKAY.
    always_comb begin
        hrdata = sel_rdata;
        hready = 1'b1;
        hresp  = HRESP_OKAY;
        if (dp_unmapped_q) begin
            hrdata = '0;
            hready = ds_hready;
            hresp  = ds_hresp;
        end else if (dp_active_q) begin
            hready = sel_ready;
            hresp  = sel_resp;
        end
    end

    ahb_default_slave #(
        .ADDR_W    (ADDR_W),
        .ERR_CNT_W (ERR_CNT_W)
    ) u_default_slave (
        .hclk_i     (hclk),
        .hresetn_i  (hresetn),
        .sample_i   (hready),
        .unmapped_i (unmapped),
        .active_i   (active),
        .haddr_i    (haddr),
        .hready_o   (ds_hready),
        .hresp_o    (ds_hresp),
        .err_cnt_o  (err_cnt),
        .err_addr_o (err_addr)
    );

endmodule

// File: tb/tb_ahb_addr_decoder_mux.sv
// Self-checking bench: directed scenarios plus a randomized run against a transfer-level model.
module tb_ahb_addr_decoder_mux;

    localparam int NS = 3;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int CW = 2;

    logic             hclk = 1'b0;
    logic             hresetn;
    logic [AW-1:0]    haddr;
    logic [1:0]       htrans;
    logic [NS-1:0]    hsel;
    logic [NS*DW-1:0] hrdata_s;
    logic [NS-1:0]    hreadyout_s;
    logic [NS-1:0]    hresp_s;
    logic [DW-1:0]    hrdata;
    logic             hready;
    logic             hresp;
    logic [CW-1:0]    err_cnt;
    logic [AW-1:0]    err_addr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 hclk = ~hclk;

    ahb_addr_decoder_mux #(
        .NUM_SLAVES (NS),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .RW         (2),
        .REGION_LSB (30),
        .ERR_CNT_W  (CW)
    ) dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .haddr       (haddr),
        .htrans      (htrans),
        .hsel        (hsel),
        .hrdata_s    (hrdata_s),
        .hreadyout_s (hreadyout_s),
        .hresp_s     (hresp_s),
        .hrdata      (hrdata),
        .hready      (hready),
        .hresp       (hresp),
        .err_cnt     (err_cnt),
        .err_addr    (err_addr)
    );

    task automatic cyc();
        @(posedge hclk);
        #1;
    endtask

    task automatic do_reset();
        hresetn = 1'b0;
        htrans  = 2'd0;
        haddr   = '0;
        hreadyout_s = '1;
        hresp_s = '0;
        cyc();
        hresetn = 1'b1;
    endtask

    task automatic test_reset();
        hresetn = 1'b0; haddr = '0; htrans = 2'd0;
        hreadyout_s = '1; hresp_s = '0; hrdata_s = '0;
        #2;
        n_checks++; if (hready !== 1'b1) begin n_fail++; $display("FAIL rst_hready: got %b exp 1", hready); end
        n_checks++; if (hresp !== 1'b0) begin n_fail++; $display("FAIL rst_hresp: got %b exp 0", hresp); end
        n_checks++; if (err_cnt !== 2'd0) begin n_fail++; $display("FAIL rst_err_cnt: got %0d exp 0", err_cnt); end
        n_checks++; if (err_addr !== 32'h0) begin n_fail++; $display("FAIL rst_err_addr: got %h exp 0", err_addr); end
        n_checks++; if (hsel !== 3'b001) begin n_fail++; $display("FAIL rst_hsel: got %b exp 001", hsel); end
        cyc();
        hresetn = 1'b1;
    endtask

    task automatic test_mapped_read();
        cyc();
        haddr = 32'h4000_0010; htrans = 2'd2; hreadyout_s = 3'b111;
        hrdata_s[DW +: DW] = 32'hA5A5_0001;
        #1;
        n_checks++; if (hsel !== 3'b010) begin n_fail++; $display("FAIL map_hsel: got %b exp 010", hsel); end
        n_checks++; if (hready !== 1'b1) begin n_fail++; $display("FAIL map_addr_hready: got %b exp 1", hready); end
        cyc();
        htrans = 2'd0; haddr = '0;
        #1;
        n_checks++; if (hrdata !== 32'hA5A5_0001) begin n_fail++; $display("FAIL map_hrdata: got %h exp a5a50001", hrdata); end
        n_checks++; if (hready !== 1'b1) begin n_fail++; $display("FAIL map_hready: got %b exp 1", hready); end
        n_checks++; if (hresp !== 1'b0) begin n_fail++; $display("FAIL map_hresp: got %b exp 0", hresp); end
    endtask

    task automatic test_stall();
        cyc();
        haddr = 32'h8000_0000; htrans = 2'd2; hreadyout_s = 3'b111;
        hrdata_s[2*DW +: DW] = 32'hD2D2_0002;
        hrdata_s[0 +: DW]    = 32'hD0D0_0000;
        cyc();
        haddr = 32'h0000_0004; htrans = 2'd2; hreadyout_s = 3'b011;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_checks++; if (hready !== 1'b0) begin n_fail++; $display("FAIL stall_hready[%0d]: got %b exp 0", k, hready); end
            n_checks++; if (hrdata !== 32'hD2D2_0002) begin n_fail++; $display("FAIL stall_hrdata[%0d]: got %h exp d2d20002", k, hrdata); end
            cyc();
        end
        hreadyout_s = 3'b111;
        #1;
        n_checks++; if (hready !== 1'b1) begin n_fail++; $display("FAIL stall_end_hready: got %b exp 1", hready); end
        n_checks++; if (hrdata !== 32'hD2D2_0002) begin n_fail++; $display("FAIL stall_end_hrdata: got %h exp d2d20002", hrdata); end
        n_checks++; if (hsel !== 3'b001) begin n_fail++; $display("FAIL stall_hsel: got %b exp 001", hsel); end
        cyc();
        htrans = 2'd0;
        #1;
        n_checks++; if (hrdata !== 32'hD0D0_0000) begin n_fail++; $display("FAIL stall_s0_hrdata: got %h exp d0d00000", hrdata); end
        n_checks++; if (hready !== 1'b1) begin n_fail++; $display("FAIL stall_s0_hready: got %b exp 1", hready); end
    endtask

    task automatic test_unmapped();
        do_reset();
        haddr = 32'hC000_0008; htrans = 2'd2;
        #1;
        n_checks++; if (hsel !== 3'b000) begin n_fail++; $display("FAIL unm_hsel: got %b exp 000", hsel); end
        cyc();
        htrans = 2'd0; haddr = '0;
        #1;
        n_checks++; if ({hready, hresp} !== 2'b01) begin n_fail++; $display("FAIL unm_err1: got rdy/resp %b exp 01", {hready, hresp}); end
        n_checks++; if (hrdata !== 32'h0) begin n_fail++; $display("FAIL unm_hrdata: got %h exp 0", hrdata); end
        cyc();
        n_checks++; if ({hready, hresp} !== 2'b11) begin n_fail++; $display("FAIL unm_err2: got rdy/resp %b exp 11", {hready, hresp}); end
        n_checks++; if (err_cnt !== 2'd1) begin n_fail++; $display("FAIL unm_err_cnt: got %0d exp 1", err_cnt); end
        n_checks++; if (err_addr !== 32'hC000_0008) begin n_fail++; $display("FAIL unm_err_addr: got %h exp c0000008", err_addr); end
        cyc();
        n_checks++; if ({hready, hresp} !== 2'b10) begin n_fail++; $display("FAIL unm_after: got rdy/resp %b exp 10", {hready, hresp}); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        haddr = 32'hC000_0000; htrans = 2'd2;
        cyc();
        haddr = 32'hC000_0004;
        #1;
        n_checks++; if ({hready, hresp} !== 2'b01) begin n_fail++; $display("FAIL b2b_a_err1: got %b exp 01", {hready, hresp}); end
        cyc();
        n_checks++; if ({hready, hresp} !== 2'b11) begin n_fail++; $display("FAIL b2b_a_err2: got %b exp 11", {hready, hresp}); end
        cyc();
        htrans = 2'd0; haddr = '0;
        #1;
        n_checks++; if ({hready, hresp} !== 2'b01) begin n_fail++; $display("FAIL b2b_b_err1: got %b exp 01", {hready, hresp}); end
        cyc();
        n_checks++; if ({hready, hresp} !== 2'b11) begin n_fail++; $display("FAIL b2b_b_err2: got %b exp 11", {hready, hresp}); end
        n_checks++; if (err_cnt !== 2'd2) begin n_fail++; $display("FAIL b2b_err_cnt: got %0d exp 2", err_cnt); end
        n_checks++; if (err_addr !== 32'hC000_0004) begin n_fail++; $display("FAIL b2b_err_addr: got %h exp c0000004", err_addr); end
        cyc();
        n_checks++; if ({hready, hresp} !== 2'b10) begin n_fail++; $display("FAIL b2b_after: got %b exp 10", {hready, hresp}); end
    endtask

    task automatic test_saturation();
        do_reset();
        // Held unmapped NONSEQ is accepted every other edge: 5 transfers in 10 edges.
        haddr = 32'hC000_0010; htrans = 2'd2;
        repeat (10) cyc();
        htrans = 2'd0;
        #1;
        n_checks++; if (err_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_err_cnt: got %0d exp 3", err_cnt); end
        cyc();
        n_checks++; if ({hready, hresp} !== 2'b10) begin n_fail++; $display("FAIL sat_idle_okay: got %b exp 10", {hready, hresp}); end
        cyc();
        n_checks++; if ({hready, hresp} !== 2'b10) begin n_fail++; $display("FAIL sat_idle_okay2: got %b exp 10", {hready, hresp}); end
        n_checks++; if (err_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_idle_cnt: got %0d exp 3", err_cnt); end
        n_checks++; if (err_addr !== 32'hC000_0010) begin n_fail++; $display("FAIL sat_err_addr: got %h exp c0000010", err_addr); end
    endtask

    task automatic test_reset_mid_error();
        do_reset();
        haddr = 32'hC000_0000; htrans = 2'd2;
        cyc();
        #1;
        n_checks++; if (hready !== 1'b0) begin n_fail++; $display("FAIL rmid_err1_hready: got %b exp 0", hready); end
        hresetn = 1'b0;
        #1;
        n_checks++; if ({hready, hresp} !== 2'b10) begin n_fail++; $display("FAIL rmid_in_reset: got %b exp 10", {hready, hresp}); end
        n_checks++; if (err_cnt !== 2'd0) begin n_fail++; $display("FAIL rmid_err_cnt: got %0d exp 0", err_cnt); end
        cyc();
        hresetn = 1'b1;
        haddr = 32'h0000_0000; htrans = 2'd2;
        hrdata_s[0 +: DW] = 32'h1234_5678;
        #1;
        n_checks++; if (hsel !== 3'b001) begin n_fail++; $display("FAIL rmid_hsel: got %b exp 001", hsel); end
        cyc();
        htrans = 2'd0;
        #1;
        n_checks++; if (hrdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rmid_hrdata: got %h exp 12345678", hrdata); end
        n_checks++; if ({hready, hresp} !== 2'b10) begin n_fail++; $display("FAIL rmid_resp: got %b exp 10", {hready, hresp}); end
    endtask

    // Transfer-level model: each accepted address phase defines the next data phase;
    // an unmapped active transfer yields a wait cycle then a completing ERROR cycle.
    task automatic test_random();
        int m_idx, m_errc, m_cnt, region;
        logic m_unm, m_act;
        logic [AW-1:0] m_addr;
        logic [NS-1:0] e_hsel;
        logic [DW-1:0] e_rd;
        logic e_rdy, e_rsp;
        do_reset();
        m_idx = 0; m_errc = 0; m_cnt = 0; m_unm = 1'b0; m_act = 1'b0; m_addr = '0;
        for (int n = 0; n < 400; n++) begin
            region = int'($urandom_range(0, 3));
            haddr  = {2'(region), 30'($urandom)};
            htrans = 2'($urandom_range(0, 3));
            for (int s = 0; s < NS; s++) begin
                hreadyout_s[s] = ($urandom_range(0, 3) != 0);
                hresp_s[s]     = ($urandom_range(0, 7) == 0);
                hrdata_s[s*DW +: DW] = $urandom;
            end
            #1;
            e_hsel = '0;
            if (region < NS) e_hsel[region] = 1'b1;
            if (m_unm) begin
                e_rd = '0;
                e_rdy = m_act ? (m_errc == 1) : 1'b1;
                e_rsp = m_act;
            end else begin
                e_rd  = hrdata_s[m_idx*DW +: DW];
                e_rdy = m_act ? hreadyout_s[m_idx] : 1'b1;
                e_rsp = m_act ? hresp_s[m_idx] : 1'b0;
            end
            n_checks++;
            if ({hsel, hready, hresp, hrdata, err_cnt, err_addr} !== {e_hsel, e_rdy, e_rsp, e_rd, 2'(m_cnt), m_addr}) begin
                n_fail++;
                $display("FAIL rand[%0d]: got hsel=%b rdy=%b resp=%b rd=%h cnt=%0d ea=%h exp hsel=%b rdy=%b resp=%b rd=%h cnt=%0d ea=%h",
                         n, hsel, hready, hresp, hrdata, err_cnt, err_addr, e_hsel, e_rdy, e_rsp, e_rd, m_cnt, m_addr);
            end
            @(posedge hclk);
            if (m_unm && m_act && m_errc == 0) begin
                m_errc = 1;
            end else if (e_rdy) begin
                m_idx  = region;
                m_unm  = (region >= NS);
                m_act  = htrans[1];
                m_errc = 0;
                if (m_unm && m_act) begin
                    m_addr = haddr;
                    if (m_cnt < 3) m_cnt++;
                end
            end
            #1;
        end
    endtask

    initial begin
        test_reset();
        test_mapped_read();
        test_stall();
        test_unmapped();
        test_back_to_back();
        test_saturation();
        test_reset_mid_error();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_addr_decoder_mux.md
Name: ahb_addr_decoder_mux

Overview:
Parametrised AHB-Lite address decoder and slave-to-master response multiplexer for N slaves.
- Decodes an address region field into a one-hot HSEL per slave.
- Tracks the data phase and routes HRDATA/HREADY/HRESP back from the selected slave.
- Contains a built-in default slave that returns the AHB two-cycle ERROR response for unmapped addresses, plus error logging.
- Sits between the master and the slave bank; replaces the fixed 4-way select decoder.

Parameters:
- NUM_SLAVES, 4, number of mapped slaves; 1..2**RW.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RW, 2, width of the region index field.
- REGION_LSB, 30, LSB of the region field; index = haddr[REGION_LSB+RW-1:REGION_LSB].
- ERR_CNT_W, 8, width of the error counter.

Ports:
- hclk  in  1  bus clock
- hresetn  in  1  asynchronous active-low reset
- haddr  in  ADDR_W  master address-phase address
- htrans  in  2  master transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
- hsel  out  NUM_SLAVES  one-hot slave select, address phase
- hrdata_s  in  NUM_SLAVES*DATA_W  packed slave read data; slave i at [i*DATA_W +: DATA_W]
- hreadyout_s  in  NUM_SLAVES  per-slave HREADYOUT
- hresp_s  in  NUM_SLAVES  per-slave HRESP (0=OKAY, 1=ERROR)
- hrdata  out  DATA_W  read data to master
- hready  out  1  bus HREADY to master and all slaves
- hresp  out  1  response to master
- err_cnt  out  ERR_CNT_W  saturating count of unmapped active transfers
- err_addr  out  ADDR_W  address of the most recent unmapped active transfer

Behaviour:
- Decode (combinational):
  - idx = region field of haddr.
  - If idx < NUM_SLAVES: hsel[idx]=1, all other bits 0, unmapped=0.
  - Otherwise: hsel all-zero, unmapped=1.
  - hsel is independent of htrans.
- Address-phase sample: occurs when hready=1 at a rising hclk edge.
  - Sampled fields: dp_idx<=idx, dp_unmapped<=unmapped, dp_active<=htrans[1].
  - When hready=0, all data-phase registers hold.
- Response mux, normal path (dp_unmapped=0):
  - dp_active=1: hrdata=hrdata_s[dp_idx], hready=hreadyout_s[dp_idx], hresp=hresp_s[dp_idx].
  - dp_active=0: hready=1, hresp=0; hrdata still muxed from dp_idx.
- Default slave FSM, states IDLE, ERR1, ERR2; used when dp_unmapped=1:
  - IDLE: hready=1, hresp=0, hrdata=0. An unmapped sample with htrans[1]=1 goes to ERR1.
  - ERR1: hready=0, hresp=1, hrdata=0. Always goes to ERR2.
  - ERR2: hready=1, hresp=1, hrdata=0. Goes to ERR1 if the next sample is an unmapped active transfer; otherwise goes to IDLE.
  - An unmapped IDLE/BUSY transfer gives a zero-wait OKAY and does not change the error log.
  - A mapped transfer sampled in ERR2 returns the FSM to IDLE, and the mux follows the new dp_idx.
- Error log, on each unmapped active sample:
  - err_addr<=haddr.
  - err_cnt increments and saturates at all-ones; no wrap.
- Reset (asynchronous, may assert mid-transfer):
  - FSM=IDLE, dp_active=0, dp_unmapped=0, dp_idx=0, err_cnt=0, err_addr=0.
  - While reset is asserted: hready=1, hresp=0.
  - Any pending wait state or ERROR is abandoned.
- Latency:
  - hsel: combinational, 0 cycles.
  - Response path: combinational from the data-phase registers. No added wait states for mapped slaves.
  - Unmapped active transfer: exactly 1 wait cycle.
- Simultaneous events: a slave stall (hreadyout_s=0) freezes the sampling, so the new address phase is held and re-presented.
- Elaboration checks:
  - NUM_SLAVES > 2**RW is an elaboration error.
  - REGION_LSB+RW > ADDR_W is an elaboration error.

Decomposition:
- Shared package ahb_pkg holds:
  - htrans encodings (HTRANS_IDLE/BUSY/NONSEQ/SEQ).
  - HRESP_OKAY/HRESP_ERROR.
  - Default-slave state typedef.
- Natural sub-module ahb_default_slave contains the FSM plus err_cnt/err_addr. Its inputs are the sample strobe, unmapped, htrans[1] and haddr; its outputs are hready/hresp.
- The decoder and mux stay in the top module.

Test Plan:
- Reset, then NONSEQ to 0x4000_0010 (slave 1), hreadyout_s=3'b111, hrdata_s[1]=0xA5A5_0001 -> hsel=3'b010 in the address phase; next cycle hrdata=0xA5A5_0001, hready=1, hresp=0.
- Slave 2 stalls 3 cycles (hreadyout_s[2]=0) on a read at 0x8000_0000 while the master presents the next address 0x0000_0004 -> hready=0 for 3 cycles, dp_idx stays 2, and slave 0's data phase starts only after the stall.
- NONSEQ to unmapped 0xC000_0008 (NUM_SLAVES=3) -> hsel=0; next cycle hready=0/hresp=1, then hready=1/hresp=1; err_cnt=1, err_addr=0xC000_0008.
- Back-to-back unmapped NONSEQs, the second sampled in ERR2 -> FSM goes ERR2 to ERR1 directly; two full ERROR pairs; err_cnt=2.
- Saturation: with ERR_CNT_W=2, send 5 unmapped transfers -> err_cnt stays 3. An unmapped IDLE transfer -> OKAY, zero-wait, count unchanged.
- Assert hresetn=0 during ERR1 -> hready=1 and hresp=0 immediately; err_cnt=0. After release, a slave 0 transfer completes normally.
